// File: rtl/trigger_pkg.sv
// -----------------------------------------------------------------------------
// trigger_pkg
// Shared definitions for the 10-bit circular trigger link (generator and
// detector sides).
//   FRAME_W         : frame length in bits, fixed by the link
//   DEFAULT_PATTERN : frame the generator emits after reset
//   state_t         : detector acquisition state, 2-bit encoding
// -----------------------------------------------------------------------------
package trigger_pkg;

  localparam int FRAME_W = 10;

  localparam logic [FRAME_W-1:0] DEFAULT_PATTERN = 10'h300;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

endpackage

// File: rtl/trigger_rx_window.sv
// -----------------------------------------------------------------------------
// trigger_rx_window
// Serial-to-parallel window for the trigger line. The line is active-low, so
// each sample is inverted before being shifted in. The first received bit
// travels up to the MSB, which matches the generator's MSB-first order.
// Ports:
//   i_clk       : link clock, one bit per rising edge
//   i_rst_n     : asynchronous active-low reset (window clears to 0)
//   i_serial_in : raw trigger line (line = ~bit)
//   i_pattern   : expected frame to compare against
//   o_window    : last FRAME_W received bits, oldest in the MSB
//   o_hit       : o_window equals i_pattern (combinational on the register)
// -----------------------------------------------------------------------------
module trigger_rx_window #(
  parameter int FRAME_W = 10
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_serial_in,
  input  logic [FRAME_W-1:0] i_pattern,
  output logic [FRAME_W-1:0] o_window,
  output logic               o_hit
);

  logic [FRAME_W-1:0] r_window;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_window <= '0;
    end else begin
      r_window <= {r_window[FRAME_W-2:0], ~i_serial_in};
    end
  end

  assign o_window = r_window;
  assign o_hit    = (r_window == i_pattern);

endmodule

// File: rtl/trigger_pattern_detector.sv
// -----------------------------------------------------------------------------
// trigger_pattern_detector
// Receive side of the circular trigger link. Hunts for the programmed frame in
// the serial stream, verifies it on LOCK_COUNT consecutive frame boundaries,
// then holds lock until UNLOCK_COUNT consecutive boundary frames mismatch.
// Ports:
//   i_clk          : link clock, one serial bit per rising edge
//   i_rst_n        : asynchronous active-low reset
//   i_serial_in    : trigger line, active-low
//   i_pattern_load : 1-cycle pulse, latch i_pattern_in and restart hunting
//   i_pattern_in   : new expected frame
//   i_err_clr      : synchronous clear of o_err_count (beats an increment)
//   o_locked       : high while in LOCKED
//   o_frame_strobe : 1-cycle pulse after each boundary in VERIFY/LOCKED
//   o_match_strobe : 1-cycle pulse after a boundary whose frame matched
//   o_rx_word      : last boundary frame
//   o_err_count    : saturating count of mismatched boundary frames in LOCKED
//   o_state        : current acquisition state (debug visibility)
// Handshake: none; every input is sampled on each rising edge and every
// strobe output is a registered single-cycle pulse with no back-pressure.
// -----------------------------------------------------------------------------
module trigger_pattern_detector
  import trigger_pkg::*;
#(
  parameter int                 FRAME_W         = trigger_pkg::FRAME_W,
  parameter logic [FRAME_W-1:0] DEFAULT_PATTERN = trigger_pkg::DEFAULT_PATTERN,
  parameter int                 LOCK_COUNT      = 3,
  parameter int                 UNLOCK_COUNT    = 2,
  parameter int                 ERR_W           = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_serial_in,
  input  logic               i_pattern_load,
  input  logic [FRAME_W-1:0] i_pattern_in,
  input  logic               i_err_clr,
  output logic               o_locked,
  output logic               o_frame_strobe,
  output logic               o_match_strobe,
  output logic [FRAME_W-1:0] o_rx_word,
  output logic [ERR_W-1:0]   o_err_count,
  output logic [1:0]         o_state
);

  generate
    if (FRAME_W != 10) begin : g_bad_frame_w
      $error("trigger_pattern_detector: FRAME_W must be 10");
    end
    if (LOCK_COUNT < 1 || LOCK_COUNT > 15) begin : g_bad_lock
      $error("trigger_pattern_detector: LOCK_COUNT must be 1..15");
    end
    if (UNLOCK_COUNT < 1 || UNLOCK_COUNT > 15) begin : g_bad_unlock
      $error("trigger_pattern_detector: UNLOCK_COUNT must be 1..15");
    end
  endgenerate

  localparam int              CNT_W    = $clog2(FRAME_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_W - 1);
  localparam logic [3:0]      LOCK_C   = 4'(LOCK_COUNT);
  localparam logic [3:0]      UNLOCK_C = 4'(UNLOCK_COUNT);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [FRAME_W-1:0] r_pattern;
  logic [CNT_W-1:0]   r_bit_cnt;
  logic [3:0]         r_good_cnt;
  logic [3:0]         r_bad_cnt;
  logic               r_frame_strobe;
  logic               r_match_strobe;
  logic [FRAME_W-1:0] r_rx_word;
  logic [ERR_W-1:0]   r_err_count;

  logic [FRAME_W-1:0] w_window;
  logic               w_hit;
  logic               w_boundary;
  logic               w_act;

  trigger_rx_window #(
    .FRAME_W (FRAME_W)
  ) u_window (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_serial_in (i_serial_in),
    .i_pattern   (r_pattern),
    .o_window    (w_window),
    .o_hit       (w_hit)
  );

  // The compare point once aligned: exactly FRAME_W shifts after the last one.
  assign w_boundary = (r_state != HUNT) && (r_bit_cnt == LAST_BIT);
  // A pattern load in the same cycle cancels everything the boundary would do.
  assign w_act      = w_boundary && !i_pattern_load;

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= HUNT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    if (i_pattern_load) begin
      w_state_nxt = HUNT;
    end else begin
      case (r_state)
        HUNT: begin
          if (w_hit) w_state_nxt = VERIFY;
        end
        VERIFY: begin
          if (w_boundary) begin
            if (!w_hit)                              w_state_nxt = HUNT;
            else if ((r_good_cnt + 4'd1) >= LOCK_C)  w_state_nxt = LOCKED;
          end
        end
        LOCKED: begin
          if (w_boundary && !w_hit && ((r_bad_cnt + 4'd1) >= UNLOCK_C))
            w_state_nxt = HUNT;
        end
        default: w_state_nxt = HUNT;
      endcase
    end
  end

  // Pattern register and alignment counters
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pattern  <= DEFAULT_PATTERN;
      r_bit_cnt  <= '0;
      r_good_cnt <= '0;
      r_bad_cnt  <= '0;
    end else if (i_pattern_load) begin
      r_pattern  <= i_pattern_in;
      r_bit_cnt  <= '0;
      r_good_cnt <= '0;
      r_bad_cnt  <= '0;
    end else begin
      case (r_state)
        HUNT: begin
          // The hunt hit itself is the first good frame.
          r_bit_cnt  <= '0;
          r_bad_cnt  <= '0;
          r_good_cnt <= w_hit ? 4'd1 : 4'd0;
        end
        VERIFY: begin
          r_bad_cnt <= '0;
          if (w_boundary) begin
            r_bit_cnt  <= '0;
            r_good_cnt <= w_hit ? (r_good_cnt + 4'd1) : 4'd0;
          end else begin
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
          end
        end
        LOCKED: begin
          r_good_cnt <= '0;
          if (w_boundary) begin
            r_bit_cnt <= '0;
            r_bad_cnt <= w_hit ? 4'd0 : (r_bad_cnt + 4'd1);
          end else begin
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_bit_cnt  <= '0;
          r_good_cnt <= '0;
          r_bad_cnt  <= '0;
        end
      endcase
    end
  end

  // Boundary strobes, captured frame and error counter
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_frame_strobe <= 1'b0;
      r_match_strobe <= 1'b0;
      r_rx_word      <= '0;
      r_err_count    <= '0;
    end else begin
      r_frame_strobe <= w_act;
      r_match_strobe <= w_act && w_hit;
      if (w_act) r_rx_word <= w_window;
      if (i_err_clr) begin
        r_err_count <= '0;
      end else if (w_act && (r_state == LOCKED) && !w_hit && (r_err_count != '1)) begin
        r_err_count <= r_err_count + ERR_W'(1);
      end
    end
  end

  // Outputs
  always_comb begin
    o_locked       = (r_state == LOCKED);
    o_state        = r_state;
    o_frame_strobe = r_frame_strobe;
    o_match_strobe = r_match_strobe;
    o_rx_word      = r_rx_word;
    o_err_count    = r_err_count;
  end

endmodule

// File: tb/tb_trigger_pattern_detector.sv
// -----------------------------------------------------------------------------
// tb_trigger_pattern_detector
// Directed bench for trigger_pattern_detector. Frames are sent MSB first with
// the line inverted. A strobe for frame n shows up on the first bit of frame
// n+1, so each send_frame call reports the strobes of the previous frame.
// -----------------------------------------------------------------------------
module tb_trigger_pattern_detector;
  import trigger_pkg::*;

  logic               clk;
  logic               rst_n;
  logic               serial_in;
  logic               pattern_load;
  logic [FRAME_W-1:0] pattern_in;
  logic               err_clr;
  logic               locked;
  logic               frame_strobe;
  logic               match_strobe;
  logic [FRAME_W-1:0] rx_word;
  logic [7:0]         err_count;
  logic [1:0]         state;

  int n_cmp = 0;
  int n_err = 0;

  // results of the last send_frame call
  int                 f_ns;
  int                 f_nm;
  logic [FRAME_W-1:0] f_rx;
  logic               f_lk1;

  localparam logic [9:0] P300 = 10'h300;
  localparam logic [9:0] B300 = 10'h301;
  localparam logic [9:0] P0F5 = 10'h0F5;
  localparam logic [9:0] B0F5 = 10'h0F4;

  trigger_pattern_detector dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_serial_in    (serial_in),
    .i_pattern_load (pattern_load),
    .i_pattern_in   (pattern_in),
    .i_err_clr      (err_clr),
    .o_locked       (locked),
    .o_frame_strobe (frame_strobe),
    .o_match_strobe (match_strobe),
    .o_rx_word      (rx_word),
    .o_err_count    (err_count),
    .o_state        (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one link bit: drive, clock it in, settle 1 time unit past the edge
  task automatic tick(input logic b, input logic ld, input logic clr);
    serial_in    = ~b;
    pattern_load = ld;
    err_clr      = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [9:0] f, input logic ld, input logic clr);
    f_ns  = 0;
    f_nm  = 0;
    f_rx  = '0;
    f_lk1 = 1'b0;
    for (int i = 0; i < FRAME_W; i++) begin
      tick(f[FRAME_W-1-i], (i == 0) ? ld : 1'b0, (i == 0) ? clr : 1'b0);
      if (frame_strobe) begin
        f_ns++;
        f_rx = rx_word;
      end
      if (match_strobe) f_nm++;
      if (i == 0) f_lk1 = locked;
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    serial_in    = 1'b1;
    pattern_load = 1'b0;
    pattern_in   = '0;
    err_clr      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_locked", locked, 0);
    check("rst_fstb", frame_strobe, 0);
    check("rst_mstb", match_strobe, 0);
    check("rst_rx", rx_word, 0);
    check("rst_err", err_count, 0);
    check("rst_state", state, 0);
    rst_n = 1'b1;

    // acquisition with a VERIFY failure on the third frame
    send_frame(P300, 0, 0);
    check("f1_state_hunt", state, 0);
    check("f1_ns", f_ns, 0);
    send_frame(P300, 0, 0);
    check("f2_state_verify", state, 1);
    check("f2_ns", f_ns, 0);
    send_frame(B300, 0, 0);
    check("f3_ns", f_ns, 1);
    check("f3_nm", f_nm, 1);
    check("f3_rx", f_rx, P300);
    send_frame(P300, 0, 0);
    check("vfail_ns", f_ns, 1);
    check("vfail_nm", f_nm, 0);
    check("vfail_rx", f_rx, B300);
    check("vfail_state_hunt", state, 0);
    check("vfail_err", err_count, 0);
    check("vfail_locked", locked, 0);
    send_frame(P300, 0, 0);
    check("f5_state_verify", state, 1);
    check("f5_ns", f_ns, 0);
    send_frame(P300, 0, 0);
    check("f6_nm", f_nm, 1);
    check("f6_locked", locked, 0);
    send_frame(P300, 0, 0);
    check("f7_locked", locked, 1);
    check("f7_lk1", f_lk1, 1);
    send_frame(P300, 0, 0);
    check("f8_ns", f_ns, 1);
    check("f8_nm", f_nm, 1);
    check("f8_rx", f_rx, P300);
    check("f8_err", err_count, 0);

    // single corrupted frame while locked
    send_frame(B300, 0, 0);
    send_frame(P300, 0, 0);
    check("one_bad_nm", f_nm, 0);
    check("one_bad_rx", f_rx, B300);
    check("one_bad_err", err_count, 1);
    check("one_bad_locked", locked, 1);
    send_frame(P300, 0, 0);
    check("one_bad_recover_nm", f_nm, 1);
    // a second isolated miss must not drop lock if the good frame reset bad_cnt
    send_frame(B300, 0, 0);
    send_frame(P300, 0, 0);
    check("bad_cnt_reset_locked", locked, 1);
    check("bad_cnt_reset_err", err_count, 2);

    // two consecutive corrupted frames drop lock
    send_frame(B300, 0, 0);
    send_frame(B300, 0, 0);
    check("two_bad_err1", err_count, 3);
    check("two_bad_lk_mid", locked, 1);
    send_frame(P300, 0, 0);
    check("two_bad_lk1", f_lk1, 0);
    check("two_bad_err2", err_count, 4);
    check("two_bad_state", state, 0);
    send_frame(P300, 0, 0);
    check("relock_verify", state, 1);
    send_frame(P300, 0, 0);
    check("relock_not_yet", locked, 0);
    send_frame(P300, 0, 0);
    check("relock_locked", locked, 1);

    // pattern load while locked on the old pattern; load coincides with a boundary
    pattern_in = P0F5;
    send_frame(P300, 1, 0);
    check("load_lk1", f_lk1, 0);
    check("load_ns", f_ns, 0);
    check("load_err", err_count, 4);
    send_frame(P300, 0, 0);
    check("load_old_ns", f_ns, 0);
    check("load_old_state", state, 0);
    send_frame(P0F5, 0, 0);
    check("new_hunt_ns", f_ns, 0);
    send_frame(P0F5, 0, 0);
    check("new_verify", state, 1);
    send_frame(P0F5, 0, 0);
    check("new_nm", f_nm, 1);
    check("new_rx", f_rx, P0F5);
    check("new_not_locked", locked, 0);
    send_frame(P0F5, 0, 0);
    check("new_locked", locked, 1);

    // saturation: each bad/good pair adds exactly one error
    for (int i = 0; i < 250; i++) begin
      send_frame(B0F5, 0, 0);
      send_frame(P0F5, 0, 0);
    end
    check("sat_254", err_count, 8'hFE);
    send_frame(B0F5, 0, 0);
    send_frame(P0F5, 0, 0);
    check("sat_255", err_count, 8'hFF);
    for (int i = 0; i < 3; i++) begin
      send_frame(B0F5, 0, 0);
      send_frame(P0F5, 0, 0);
    end
    check("sat_hold", err_count, 8'hFF);
    check("sat_locked", locked, 1);

    // clear coincident with a mismatch increment
    send_frame(B0F5, 0, 0);
    send_frame(P0F5, 0, 1);
    check("clr_win_nm", f_nm, 0);
    check("clr_win_err", err_count, 0);
    send_frame(P0F5, 0, 0);
    send_frame(B0F5, 0, 0);
    send_frame(P0F5, 0, 0);
    check("clr_after_err", err_count, 1);
    check("clr_after_locked", locked, 1);

    // asynchronous reset mid-frame, right while a strobe is high
    tick(P0F5[9], 0, 0);
    check("pre_rst_fstb", frame_strobe, 1);
    check("pre_rst_locked", locked, 1);
    rst_n = 1'b0;
    #2;
    check("arst_locked", locked, 0);
    check("arst_fstb", frame_strobe, 0);
    check("arst_mstb", match_strobe, 0);
    check("arst_rx", rx_word, 0);
    check("arst_err", err_count, 0);
    check("arst_state", state, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // default pattern is restored by reset
    send_frame(P300, 0, 0);
    send_frame(P300, 0, 0);
    check("post_rst_verify", state, 1);
    send_frame(P300, 0, 0);
    check("post_rst_nm", f_nm, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/trigger_pattern_detector.md
Name: trigger_pattern_detector

Overview:
- Receive-side counterpart of the 10-bit circular trigger pattern generator: samples the serial trigger line, deserializes it MSB-first and hunts for the programmed 10-bit frame.
- Acquires and holds frame lock, emits one strobe per received frame and counts frame errors.
- Sits at the far end of the trigger link, feeding downstream trigger/timing logic.

Parameters:
- FRAME_W, 10, frame length in bits (fixed by the link; checked at elaboration).
- DEFAULT_PATTERN, 10'h300, expected frame after reset.
- LOCK_COUNT, 3, consecutive matching frames needed in VERIFY to declare lock (1..15).
- UNLOCK_COUNT, 2, consecutive mismatching frames in LOCKED that drop lock (1..15).
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  link clock; one serial bit per rising edge.
- rst_n  in  1  asynchronous active-low reset.
- serial_in  in  1  trigger line; active-low (line = ~bit).
- pattern_load  in  1  one-cycle pulse: latch pattern_in and restart acquisition.
- pattern_in  in  FRAME_W  new expected pattern.
- err_clr  in  1  synchronous clear of err_count.
- locked  out  1  high while in LOCKED.
- frame_strobe  out  1  one-cycle pulse at every frame boundary while in VERIFY or LOCKED.
- match_strobe  out  1  one-cycle pulse when a boundary frame equals the pattern.
- rx_word  out  FRAME_W  last complete frame, updated at each boundary.
- err_count  out  ERR_W  saturating count of mismatched boundary frames while LOCKED.

Behaviour:
- Reset (async, rst_n low):
  - state=HUNT; window=0; bit_cnt=0; good_cnt=0; bad_cnt=0.
  - pattern_q=DEFAULT_PATTERN.
  - All outputs 0.
- Shift (every edge, all states): window <= {window[FRAME_W-2:0], ~serial_in}. The first received bit ends up in the MSB.
- hit = (window == pattern_q), combinational on the registered window.
- HUNT:
  - On hit: next edge -> VERIFY, bit_cnt<=0, good_cnt<=1.
  - No strobes in HUNT.
- Boundary: in VERIFY/LOCKED, the cycle with bit_cnt==FRAME_W-1. bit_cnt counts 0..FRAME_W-1 and wraps.
  - This gives exactly FRAME_W shifts between consecutive compares.
- At each boundary edge:
  - frame_strobe<=1; rx_word<=window; match_strobe<=hit.
  - All strobes are registered: 1-cycle latency from the boundary cycle.
- VERIFY:
  - Boundary with hit: good_cnt+1; on reaching LOCK_COUNT -> LOCKED, locked<=1, bad_cnt<=0.
  - Boundary with miss: -> HUNT, good_cnt<=0. No error counted.
- LOCKED:
  - Boundary with hit: bad_cnt<=0.
  - Boundary with miss: bad_cnt+1, err_count+1 (saturate at all-ones). On reaching UNLOCK_COUNT -> HUNT, locked<=0.
  - The lock-dropping frame is itself counted.
- pattern_load:
  - Next edge: pattern_q<=pattern_in; -> HUNT; counters cleared; locked<=0.
  - Suppresses any boundary action in that cycle (load wins). err_count is not cleared.
- err_clr:
  - err_count<=0.
  - If err_clr coincides with an increment, the clear wins.
- A pattern of all zeros or all ones is legal. Any hit satisfies alignment, since there is no ambiguity check.
- Reset mid-frame returns to HUNT immediately. Outputs drop asynchronously.

Decomposition:
- Package trigger_pkg:
  - FRAME_W constant.
  - State enum {HUNT, VERIFY, LOCKED} with 2-bit encoding.
  - DEFAULT_PATTERN constant, shared with the generator.
- Sub-module trigger_rx_window: the serial-to-parallel window register with input inversion, outputting window and hit.
- The FSM, counters and strobes stay in the top level.

Test Plan:
- Reset then drive the generator pattern 10'h300 continuously (line = ~bit, MSB first):
  - HUNT hit after 10 bits; locked rises after 3 matching boundaries.
  - frame_strobe every 10 cycles; rx_word=10'h300; err_count=0.
- Locked, then corrupt one bit of one frame:
  - match_strobe=0 for that frame; err_count=1; locked stays 1.
  - Next good frame resets bad_cnt.
- Locked, then corrupt two consecutive frames:
  - err_count=2; locked falls 1 cycle after the second boundary.
  - Relock after the next hit + 3 frames.
- In VERIFY, corrupt the second frame: return to HUNT, no err increment, locked never asserted.
- While locked, pulse pattern_load with 10'h0F5 while the line still carries 10'h300:
  - locked=0 next cycle; no further strobes.
  - Switching the line to 10'h0F5 relocks after 3 frames.
- Saturation and reset:
  - Preload err_count near all-ones via repeated mismatches; it holds at 8'hFF.
  - err_clr coincident with a mismatch yields 0.
  - rst_n low mid-frame clears all outputs asynchronously.
